// File: rtl/adc_multi_clock_sync.sv
// Brings slave ADCs into phase with the ADC0 master one at a time, in the dcm_psclk domain.
// Optional watchdog on WAIT_DCM/SAMPLE is built only when ADC_SYNC_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INIT     | power-up delay of INIT_DELAY cycles
// RESET    | one-cycle reset pulse to slave sel on master phase reset_phase
// WAIT_ADC | RESET_WAIT cycles for the slave ADC to come back up
// WAIT_DCM | samplers held in reset until master and slave DCMs are locked
// SAMPLE   | sample request until every phase of slave sel is valid
// DECIDE   | compare captured phase pattern against the target
// NEXT     | advance to next slave or finish
// DONE     | sequence complete, waiting for resync
module adc_multi_clock_sync #(
    parameter int NUM_SLAVES     = 1,
    parameter int NUM_PHASES     = 4,
    parameter int INIT_DELAY     = 125000000,
    parameter int RESET_WAIT     = 2000,
    parameter int MAX_RETRIES    = 16,
    parameter logic [NUM_PHASES-1:0] TARGET_MASK = 4'b0110,
    parameter logic [NUM_PHASES-1:0] TARGET_VAL  = 4'b0010,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_WIDTH      = 32,
    localparam int SEL_W         = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1,
    localparam int PH_W          = $clog2(NUM_PHASES)
) (
    input  logic                             dcm_psclk,
    input  logic                             ctrl_reset,
    input  logic                             resync,
    input  logic [NUM_SLAVES:0]              dcm_locked,
    input  logic [NUM_SLAVES*NUM_PHASES-1:0] sample_data,
    input  logic [NUM_SLAVES*NUM_PHASES-1:0] sample_valid,
    output logic                             sampler_rst,
    output logic                             sample_req,
    output logic [NUM_SLAVES-1:0]            slave_reset_start,
    output logic [PH_W-1:0]                  reset_phase,
    output logic [SEL_W-1:0]                 active_slave,
    output logic [NUM_SLAVES-1:0]            sync_ok,
    output logic [NUM_SLAVES-1:0]            sync_fail,
    output logic                             sync_done,
    output logic                             timeout_flag
);

    typedef enum logic [2:0] {
        S_INIT, S_RESET, S_WAIT_ADC, S_WAIT_DCM, S_SAMPLE, S_DECIDE, S_NEXT, S_DONE
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [SEL_W-1:0]        sel;
    logic [7:0]              retry_cnt;
    logic [PH_W-1:0]         phase;
    logic [NUM_SLAVES-1:0]   ok_q, fail_q, sel_onehot;
    logic [NUM_PHASES-1:0]   sample_q, cur_data, cur_valid;
    logic                    sel_locked, all_valid, match, pass, retry_last, last_slave;
    logic                    cnt_en, timeout_go, force_fail;

    always_comb begin
        cur_data   = '0;
        cur_valid  = '0;
        sel_locked = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                cur_data      = sample_data[i*NUM_PHASES +: NUM_PHASES];
                cur_valid     = sample_valid[i*NUM_PHASES +: NUM_PHASES];
                sel_locked    = dcm_locked[0] & dcm_locked[i+1];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign all_valid  = &cur_valid;
    assign match      = ((sample_q & TARGET_MASK) == TARGET_VAL);
    assign pass       = match & ~force_fail;
    assign retry_last = ((retry_cnt + 8'd1) == 8'(MAX_RETRIES));
    assign last_slave = (sel == SEL_W'(NUM_SLAVES - 1));
    assign cnt_en     = (state == S_INIT) || (state == S_WAIT_ADC);

`ifdef ADC_SYNC_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_hit, tmo_q, force_q;

    assign wd_hit     = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    // A normal exit in the same cycle as the watchdog hit takes priority.
    assign timeout_go = wd_hit && (((state == S_WAIT_DCM) && !sel_locked) ||
                                   ((state == S_SAMPLE) && !all_valid));

    always_ff @(posedge dcm_psclk) begin
        if (ctrl_reset) begin
            wd_cnt  <= '0;
            tmo_q   <= 1'b0;
            force_q <= 1'b0;
        end else begin
            wd_cnt  <= (((state == S_WAIT_DCM) || (state == S_SAMPLE)) && (state_nxt == state))
                       ? wd_cnt + 32'd1 : '0;
            force_q <= timeout_go;
            if (timeout_go)
                tmo_q <= 1'b1;
        end
    end

    assign force_fail   = force_q;
    assign timeout_flag = tmo_q;
`else
    assign timeout_go   = 1'b0;
    assign force_fail   = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:     if (cnt == CNT_WIDTH'(INIT_DELAY - 1)) state_nxt = S_RESET;
            S_RESET:    state_nxt = S_WAIT_ADC;
            S_WAIT_ADC: if (cnt == CNT_WIDTH'(RESET_WAIT - 1)) state_nxt = S_WAIT_DCM;
            S_WAIT_DCM: if (sel_locked) state_nxt = S_SAMPLE;
                        else if (timeout_go) state_nxt = S_DECIDE;
            S_SAMPLE:   if (all_valid || timeout_go) state_nxt = S_DECIDE;
            S_DECIDE:   state_nxt = (pass || retry_last) ? S_NEXT : S_RESET;
            S_NEXT:     state_nxt = last_slave ? S_DONE : S_RESET;
            S_DONE:     if (resync) state_nxt = S_RESET;
            default:    state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge dcm_psclk) begin
        if (ctrl_reset) begin
            state     <= S_INIT;
            cnt       <= '0;
            sel       <= '0;
            retry_cnt <= '0;
            phase     <= '0;
            ok_q      <= '0;
            fail_q    <= '0;
            sample_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (cnt_en && (state_nxt == state)) ? cnt + CNT_WIDTH'(1) : '0;
            if ((state == S_SAMPLE) && all_valid)
                sample_q <= cur_data;
            case (state)
                S_DECIDE: begin
                    if (pass) begin
                        ok_q <= ok_q | sel_onehot;
                    end else begin
                        retry_cnt <= retry_cnt + 8'd1;
                        phase     <= phase + PH_W'(1);
                        if (retry_last)
                            fail_q <= fail_q | sel_onehot;
                    end
                end
                S_NEXT: begin
                    retry_cnt <= '0;
                    phase     <= '0;
                    if (!last_slave)
                        sel <= sel + SEL_W'(1);
                end
                S_DONE: begin
                    if (resync) begin
                        ok_q   <= '0;
                        fail_q <= '0;
                        sel    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sampler_rst       = (state == S_WAIT_DCM);
    assign sample_req        = (state == S_SAMPLE);
    assign slave_reset_start = (state == S_RESET) ? sel_onehot : '0;
    assign reset_phase       = phase;
    assign active_slave      = sel;
    assign sync_ok           = ok_q;
    assign sync_fail         = fail_q;
    assign sync_done         = (state == S_DONE);

endmodule

// File: tb/tb_adc_multi_clock_sync.sv
// Directed bench for adc_multi_clock_sync with two slaves, short delays and three retries.
module tb_adc_multi_clock_sync;

    logic       dcm_psclk = 1'b0;
    logic       ctrl_reset = 1'b1;
    logic       resync = 1'b0;
    logic [2:0] dcm_locked = 3'b111;
    logic [7:0] sample_data;
    logic [7:0] sample_valid = 8'hFF;
    logic       sampler_rst, sample_req, sync_done, timeout_flag;
    logic [1:0] slave_reset_start, reset_phase, sync_ok, sync_fail;
    logic       active_slave;

    adc_multi_clock_sync #(
        .NUM_SLAVES(2), .NUM_PHASES(4), .INIT_DELAY(10), .RESET_WAIT(5), .MAX_RETRIES(3),
        .TARGET_MASK(4'b0110), .TARGET_VAL(4'b0010), .TIMEOUT_CYCLES(20), .CNT_WIDTH(32)
    ) dut (
        .dcm_psclk(dcm_psclk), .ctrl_reset(ctrl_reset), .resync(resync),
        .dcm_locked(dcm_locked), .sample_data(sample_data), .sample_valid(sample_valid),
        .sampler_rst(sampler_rst), .sample_req(sample_req),
        .slave_reset_start(slave_reset_start), .reset_phase(reset_phase),
        .active_slave(active_slave), .sync_ok(sync_ok), .sync_fail(sync_fail),
        .sync_done(sync_done), .timeout_flag(timeout_flag)
    );

    always #5 dcm_psclk = ~dcm_psclk;

    typedef struct {
        logic [1:0] start;
        logic [1:0] phase;
        int         cyc;
    } pulse_t;

    pulse_t     plog[$];
    int         checks = 0, errors = 0, pw_errors = 0, cyc = 0;
    int         s0_pulses = 0, s1_pulses = 0;
    int         s0_base = 0, s1_base = 0, s0_fail_n = 0, s1_fail_n = 0, pbase = 0;
    logic [1:0] prev_start = 2'b00;

    always @(posedge dcm_psclk) cyc++;

    // Log every reset pulse; a pulse seen on two consecutive cycles is a width error.
    always @(negedge dcm_psclk) begin
        if (slave_reset_start != 2'b00) begin
            plog.push_back('{slave_reset_start, reset_phase, cyc});
            if (slave_reset_start[0]) s0_pulses++;
            if (slave_reset_start[1]) s1_pulses++;
            if (prev_start != 2'b00) begin
                pw_errors++;
                $display("FAIL pulse_width: start=%b on consecutive cycles, required single cycle", slave_reset_start);
            end
        end
        prev_start = slave_reset_start;
    end

    // Slave i returns a failing pattern on its first fail_n attempts, then the target.
    always_comb begin
        sample_data[3:0] = ((s0_pulses - s0_base) <= s0_fail_n) ? 4'b0100 : 4'b0010;
        sample_data[7:4] = ((s1_pulses - s1_base) <= s1_fail_n) ? 4'b0100 : 4'b0010;
    end

    task automatic hold_reset(input int f0, input int f1, input logic [2:0] lk, input logic [7:0] vld);
        ctrl_reset   = 1'b1;
        s0_fail_n    = f0;
        s1_fail_n    = f1;
        dcm_locked   = lk;
        sample_valid = vld;
        repeat (2) @(negedge dcm_psclk);
        s0_base = s0_pulses;
        s1_base = s1_pulses;
        pbase   = plog.size();
    endtask

    task automatic wait_done(input string name, input int lim);
        int n = 0;
        while (sync_done !== 1'b1 && n < lim) begin
            @(negedge dcm_psclk);
            n++;
        end
        checks++;
        if (sync_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_timeout: sync_done=%b after %0d cycles, required 1", name, sync_done, n);
        end
    endtask

    task automatic check_restart_delay(input string name);
        int n = 0;
        ctrl_reset = 1'b0;
        do begin
            @(negedge dcm_psclk);
            n++;
        end while (slave_reset_start == 2'b00 && n < 50);
        checks++;
        if (n !== 10 || slave_reset_start !== 2'b01) begin
            errors++;
            $display("FAIL %s_init_delay: first pulse %b after %0d cycles, required 01 after 10", name, slave_reset_start, n);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({sampler_rst, sample_req, slave_reset_start, reset_phase, active_slave,
             sync_ok, sync_fail, sync_done, timeout_flag} !== 13'b0) begin
            errors++;
            $display("FAIL %s_outputs_zero: rst=%b req=%b start=%b ph=%0d act=%0d ok=%b fail=%b done=%b tmo=%b, required all 0",
                     name, sampler_rst, sample_req, slave_reset_start, reset_phase, active_slave,
                     sync_ok, sync_fail, sync_done, timeout_flag);
        end
    endtask

    task automatic check_pulse(input string name, input int idx, input logic [1:0] st, input logic [1:0] ph);
        checks++;
        if (plog.size() <= pbase + idx) begin
            errors++;
            $display("FAIL %s_pulse%0d: missing, required start=%b phase=%0d", name, idx, st, ph);
        end else if (plog[pbase+idx].start !== st || plog[pbase+idx].phase !== ph) begin
            errors++;
            $display("FAIL %s_pulse%0d: start=%b phase=%0d, required start=%b phase=%0d",
                     name, idx, plog[pbase+idx].start, plog[pbase+idx].phase, st, ph);
        end
    endtask

    task automatic check_flags(input string name, input int npulse, input logic [1:0] ok, input logic [1:0] fl);
        checks++;
        if (plog.size() - pbase !== npulse || sync_ok !== ok || sync_fail !== fl) begin
            errors++;
            $display("FAIL %s_flags: pulses=%0d ok=%b fail=%b, required pulses=%0d ok=%b fail=%b",
                     name, plog.size() - pbase, sync_ok, sync_fail, npulse, ok, fl);
        end
    endtask

    task automatic check_gap(input string name, input int idx, input int gap);
        checks++;
        if (plog.size() <= pbase + idx + 1) begin
            errors++;
            $display("FAIL %s_gap: pulses missing, required gap %0d", name, gap);
        end else if (plog[pbase+idx+1].cyc - plog[pbase+idx].cyc !== gap) begin
            errors++;
            $display("FAIL %s_gap: %0d cycles between pulses, required %0d",
                     name, plog[pbase+idx+1].cyc - plog[pbase+idx].cyc, gap);
        end
    endtask

    task automatic test_reset();
        hold_reset(0, 0, 3'b111, 8'hFF);
        check_all_zero("reset");
        check_restart_delay("reset");
    endtask

    task automatic test_all_pass();
        wait_done("all_pass", 200);
        check_pulse("all_pass", 0, 2'b01, 2'd0);
        check_pulse("all_pass", 1, 2'b10, 2'd0);
        check_gap("all_pass", 0, 10);
        check_flags("all_pass", 2, 2'b11, 2'b00);
        checks++;
        if (timeout_flag !== 1'b0 || active_slave !== 1'b1) begin
            errors++;
            $display("FAIL all_pass_status: tmo=%b act=%0d, required tmo=0 act=1", timeout_flag, active_slave);
        end
    endtask

    task automatic test_retry_pass();
        hold_reset(2, 0, 3'b111, 8'hFF);
        ctrl_reset = 1'b0;
        wait_done("retry_pass", 300);
        check_pulse("retry_pass", 0, 2'b01, 2'd0);
        check_pulse("retry_pass", 1, 2'b01, 2'd1);
        check_pulse("retry_pass", 2, 2'b01, 2'd2);
        check_pulse("retry_pass", 3, 2'b10, 2'd0);
        check_gap("retry_pass", 0, 9);
        check_flags("retry_pass", 4, 2'b11, 2'b00);
    endtask

    task automatic test_slave_fail();
        hold_reset(0, 255, 3'b111, 8'hFF);
        ctrl_reset = 1'b0;
        wait_done("slave_fail", 300);
        check_pulse("slave_fail", 1, 2'b10, 2'd0);
        check_pulse("slave_fail", 2, 2'b10, 2'd1);
        check_pulse("slave_fail", 3, 2'b10, 2'd2);
        check_flags("slave_fail", 4, 2'b01, 2'b10);
    endtask

    task automatic test_resync();
        s1_fail_n = 0;
        s1_base   = s1_pulses;
        pbase     = plog.size();
        resync    = 1'b1;
        @(negedge dcm_psclk);
        resync = 1'b0;
        checks++;
        if (sync_ok !== 2'b00 || sync_fail !== 2'b00 || slave_reset_start !== 2'b01 || sync_done !== 1'b0) begin
            errors++;
            $display("FAIL resync_restart: ok=%b fail=%b start=%b done=%b, required ok=00 fail=00 start=01 done=0",
                     sync_ok, sync_fail, slave_reset_start, sync_done);
        end
        repeat (2) @(negedge dcm_psclk);
        resync = 1'b1;
        @(negedge dcm_psclk);
        resync = 1'b0;
        wait_done("resync", 200);
        check_flags("resync", 2, 2'b11, 2'b00);
    endtask

    task automatic test_reset_in_sample();
        int n = 0;
        hold_reset(0, 0, 3'b111, 8'h0F);
        ctrl_reset = 1'b0;
        while (!(sample_req === 1'b1 && active_slave === 1'b1) && n < 200) begin
            @(negedge dcm_psclk);
            n++;
        end
        checks++;
        if (sample_req !== 1'b1 || active_slave !== 1'b1 || sync_ok !== 2'b01) begin
            errors++;
            $display("FAIL stall_sample: req=%b act=%0d ok=%b, required req=1 act=1 ok=01", sample_req, active_slave, sync_ok);
        end
        ctrl_reset = 1'b1;
        @(negedge dcm_psclk);
        check_all_zero("mid_reset");
        sample_valid = 8'hFF;
        check_restart_delay("mid_reset");
    endtask

`ifdef ADC_SYNC_TIMEOUT_EN
    task automatic test_timeout();
        hold_reset(0, 0, 3'b011, 8'hFF);
        ctrl_reset = 1'b0;
        wait_done("timeout", 400);
        check_pulse("timeout", 3, 2'b10, 2'd2);
        check_gap("timeout", 1, 27);
        check_flags("timeout", 4, 2'b01, 2'b10);
        checks++;
        if (timeout_flag !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag: %b, required 1", timeout_flag);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_all_pass();
        test_retry_pass();
        test_slave_fail();
        test_resync();
        test_reset_in_sample();
`ifdef ADC_SYNC_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (pw_errors !== 0) begin
            errors++;
            $display("FAIL pulse_width_total: %0d over-long pulses, required 0", pw_errors);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
